// File: rtl/viol_reset_sequencer_if.sv
// Bundles the monitor-request, core-status and sequencer-status signals of viol_reset_sequencer.
// The master side (monitors/core) drives requests; the slave side (sequencer) drives reset and status.
interface viol_reset_sequencer_if #(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 8
);
    logic [NUM_SRC-1:0] viol_req;
    logic [15:0]        pc;
    logic               gie;
    logic               cause_clr;
    logic               sys_reset;
    logic [NUM_SRC-1:0] cause;
    logic [CNT_W-1:0]   reset_count;
    logic               timeout_err;
    logic               busy;

    modport master (
        output viol_req, pc, gie, cause_clr,
        input  sys_reset, cause, reset_count, timeout_err, busy
    );

    modport slave (
        input  viol_req, pc, gie, cause_clr,
        output sys_reset, cause, reset_count, timeout_err, busy
    );
endinterface

// File: rtl/viol_reset_sequencer.sv
// Turns violation-monitor requests into a timed MCU reset, then waits for the core to
// fetch the reset handler with interrupts disabled before re-arming.
module viol_reset_sequencer #(
    parameter int          NUM_SRC       = 2,
    parameter int          HOLD_CYCLES   = 8,
    parameter int          TIMEOUT       = 64,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int          CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    viol_reset_sequencer_if.slave  io_bus
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic [1:0]         r_state;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_sys_reset;
    logic [NUM_SRC-1:0] r_cause;
    logic [CNT_W-1:0]   r_reset_count;
    logic               r_timeout_err;
    logic               r_busy;

    logic               w_any_req;
    logic               w_confirm;

    assign w_any_req = |io_bus.viol_req;
    // Only a handler fetch with interrupts masked proves the core really restarted.
    assign w_confirm = (io_bus.pc == RESET_HANDLER) && !io_bus.gie;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_ASSERT;
            r_hold_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_sys_reset   <= 1'b1;
            r_cause       <= '0;
            r_reset_count <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_ASSERT;
                        r_sys_reset <= 1'b1;
                        r_busy      <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_cause     <= io_bus.cause_clr ? io_bus.viol_req
                                                        : (r_cause | io_bus.viol_req);
                        if (r_reset_count != '1) begin
                            r_reset_count <= r_reset_count + 1'b1;
                        end
                    end else if (io_bus.cause_clr) begin
                        r_cause <= '0;
                    end
                end

                ST_ASSERT: begin
                    if (w_any_req) begin
                        r_cause    <= r_cause | io_bus.viol_req;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state     <= ST_WAIT;
                        r_sys_reset <= 1'b0;
                        r_wait_cnt  <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    // Requests are ignored here; monitors stay asserted until the handler runs.
                    if (w_confirm) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state       <= ST_ASSERT;
                        r_sys_reset   <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_hold_cnt    <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_ASSERT;
                    r_sys_reset <= 1'b1;
                    r_busy      <= 1'b1;
                    r_hold_cnt  <= '0;
                end
            endcase
        end
    end

    assign io_bus.sys_reset   = r_sys_reset;
    assign io_bus.cause       = r_cause;
    assign io_bus.reset_count = r_reset_count;
    assign io_bus.timeout_err = r_timeout_err;
    assign io_bus.busy        = r_busy;
endmodule

// File: tb/tb_viol_reset_sequencer.sv
// Directed bench for viol_reset_sequencer: power-on, violation, extension, timeout,
// confirm qualification, cause clearing, counter saturation and async reset.
module tb_viol_reset_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    viol_reset_sequencer_if #(.NUM_SRC(2), .CNT_W(8)) bus_if ();

    viol_reset_sequencer #(
        .NUM_SRC(2), .HOLD_CYCLES(8), .TIMEOUT(64), .RESET_HANDLER(16'h0000), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .io_bus(bus_if.slave)
    );

    // Advance to 1 time unit past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts observed cycles with sys_reset high, optionally injecting a request on one of them.
    task automatic count_high(input logic [1:0] inj, input int inj_at, output int n);
        n = 0;
        while (bus_if.sys_reset === 1'b1 && n < 200) begin
            n++;
            if (n == inj_at) bus_if.viol_req = inj;
            step();
            bus_if.viol_req = 2'b00;
        end
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (bus_if.sys_reset === 1'b0 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic trigger(input logic [1:0] req);
        bus_if.viol_req = req;
        step();
        bus_if.viol_req = 2'b00;
    endtask

    task automatic test_reset();
        int n;
        bus_if.viol_req = 2'b00; bus_if.pc = 16'h0000; bus_if.gie = 1'b0; bus_if.cause_clr = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus_if.sys_reset !== 1'b1) begin n_err++; $display("FAIL rst_sys_reset: got %b want 1", bus_if.sys_reset); end
        n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", bus_if.busy); end
        n_cmp++; if (bus_if.timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout_err: got %b want 0", bus_if.timeout_err); end
        reset_n = 1'b1;
        count_high(2'b00, 0, n);
        n_cmp++; if (n != 8) begin n_err++; $display("FAIL por_hold_len: got %0d want 8", n); end
        step();
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL por_idle_busy: got %b want 0", bus_if.busy); end
        n_cmp++; if (bus_if.reset_count !== 8'd0) begin n_err++; $display("FAIL por_count: got %0d want 0", bus_if.reset_count); end
        n_cmp++; if (bus_if.cause !== 2'b00) begin n_err++; $display("FAIL por_cause: got %b want 00", bus_if.cause); end
    endtask

    task automatic test_single();
        int n;
        trigger(2'b01);
        exp_cnt++;
        count_high(2'b00, 0, n);
        n_cmp++; if (n != 8) begin n_err++; $display("FAIL single_hold_len: got %0d want 8", n); end
        n_cmp++; if (bus_if.cause !== 2'b01) begin n_err++; $display("FAIL single_cause: got %b want 01", bus_if.cause); end
        n_cmp++; if (bus_if.reset_count !== 8'(exp_cnt)) begin n_err++; $display("FAIL single_count: got %0d want %0d", bus_if.reset_count, exp_cnt); end
        n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL single_wait_busy: got %b want 1", bus_if.busy); end
        step();
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy %b want 0", bus_if.busy); end
    endtask

    task automatic test_extension();
        int n;
        bus_if.cause_clr = 1'b1;
        step();
        bus_if.cause_clr = 1'b0;
        n_cmp++; if (bus_if.cause !== 2'b00) begin n_err++; $display("FAIL ext_pre_clear: got %b want 00", bus_if.cause); end
        trigger(2'b01);
        exp_cnt++;
        count_high(2'b10, 6, n);
        n_cmp++; if (n != 14) begin n_err++; $display("FAIL ext_hold_len: got %0d want 14", n); end
        n_cmp++; if (bus_if.cause !== 2'b11) begin n_err++; $display("FAIL ext_cause: got %b want 11", bus_if.cause); end
        n_cmp++; if (bus_if.reset_count !== 8'(exp_cnt)) begin n_err++; $display("FAIL ext_count: got %0d want %0d", bus_if.reset_count, exp_cnt); end
        step();
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL ext_idle: got busy %b want 0", bus_if.busy); end
    endtask

    task automatic test_timeout();
        int n;
        bus_if.pc = 16'h0010;
        trigger(2'b01);
        exp_cnt++;
        count_high(2'b00, 0, n);
        n_cmp++; if (bus_if.timeout_err !== 1'b0) begin n_err++; $display("FAIL to_err_early: got %b want 0", bus_if.timeout_err); end
        count_low(n);
        n_cmp++; if (n != 64) begin n_err++; $display("FAIL to_wait_len: got %0d want 64", n); end
        n_cmp++; if (bus_if.timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", bus_if.timeout_err); end
        n_cmp++; if (bus_if.reset_count !== 8'(exp_cnt)) begin n_err++; $display("FAIL to_count: got %0d want %0d", bus_if.reset_count, exp_cnt); end
        bus_if.pc = 16'h0000;
        count_high(2'b00, 0, n);
        n_cmp++; if (n != 8) begin n_err++; $display("FAIL to_rehold_len: got %0d want 8", n); end
        step();
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL to_idle: got busy %b want 0", bus_if.busy); end
    endtask

    task automatic test_confirm();
        int n;
        bus_if.gie = 1'b1;
        trigger(2'b01);
        exp_cnt++;
        count_high(2'b00, 0, n);
        repeat (10) step();
        n_cmp++; if (bus_if.busy !== 1'b1 || bus_if.sys_reset !== 1'b0) begin
            n_err++; $display("FAIL conf_gie_hold: got busy %b sys_reset %b want 1 0", bus_if.busy, bus_if.sys_reset);
        end
        bus_if.gie = 1'b0;
        step();
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL conf_idle: got busy %b want 0", bus_if.busy); end
        n_cmp++; if (bus_if.reset_count !== 8'(exp_cnt)) begin n_err++; $display("FAIL conf_count: got %0d want %0d", bus_if.reset_count, exp_cnt); end
    endtask

    task automatic test_cause_clear();
        int n;
        n_cmp++; if (bus_if.cause !== 2'b11) begin n_err++; $display("FAIL clr_sticky: got %b want 11", bus_if.cause); end
        bus_if.cause_clr = 1'b1;
        step();
        bus_if.cause_clr = 1'b0;
        n_cmp++; if (bus_if.cause !== 2'b00) begin n_err++; $display("FAIL clr_idle: got %b want 00", bus_if.cause); end
        bus_if.cause_clr = 1'b1;
        trigger(2'b10);
        bus_if.cause_clr = 1'b0;
        exp_cnt++;
        n_cmp++; if (bus_if.cause !== 2'b10 || bus_if.sys_reset !== 1'b1) begin
            n_err++; $display("FAIL clr_with_req: got cause %b sys_reset %b want 10 1", bus_if.cause, bus_if.sys_reset);
        end
        bus_if.cause_clr = 1'b1;
        step();
        bus_if.cause_clr = 1'b0;
        n_cmp++; if (bus_if.cause !== 2'b10) begin n_err++; $display("FAIL clr_in_assert: got %b want 10", bus_if.cause); end
        count_high(2'b00, 0, n);
        n_cmp++; if (n != 7) begin n_err++; $display("FAIL clr_hold_rest: got %0d want 7", n); end
        step();
        n_cmp++; if (bus_if.reset_count !== 8'(exp_cnt)) begin n_err++; $display("FAIL clr_count: got %0d want %0d", bus_if.reset_count, exp_cnt); end
    endtask

    task automatic test_saturation();
        int n;
        for (int i = 0; i < 300; i++) begin
            trigger(2'b01);
            count_high(2'b00, 0, n);
            step();
            if (exp_cnt < 255) exp_cnt++;
        end
        n_cmp++; if (bus_if.reset_count !== 8'(exp_cnt) || exp_cnt != 255) begin
            n_err++; $display("FAIL sat_count: got %0d want 255", bus_if.reset_count);
        end
        n_cmp++; if (bus_if.timeout_err !== 1'b1) begin n_err++; $display("FAIL sat_err_sticky: got %b want 1", bus_if.timeout_err); end
    endtask

    task automatic test_async_reset();
        int n;
        bus_if.pc = 16'h0010;
        trigger(2'b01);
        count_high(2'b00, 0, n);
        step();
        step();
        n_cmp++; if (bus_if.busy !== 1'b1 || bus_if.sys_reset !== 1'b0) begin
            n_err++; $display("FAIL arst_in_wait: got busy %b sys_reset %b want 1 0", bus_if.busy, bus_if.sys_reset);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus_if.sys_reset !== 1'b1) begin n_err++; $display("FAIL arst_sys_reset: got %b want 1", bus_if.sys_reset); end
        n_cmp++; if (bus_if.cause !== 2'b00) begin n_err++; $display("FAIL arst_cause: got %b want 00", bus_if.cause); end
        n_cmp++; if (bus_if.reset_count !== 8'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", bus_if.reset_count); end
        n_cmp++; if (bus_if.timeout_err !== 1'b0) begin n_err++; $display("FAIL arst_err: got %b want 0", bus_if.timeout_err); end
        n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL arst_busy: got %b want 1", bus_if.busy); end
        bus_if.pc = 16'h0000;
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_extension();
        test_timeout();
        test_confirm();
        test_cause_clear();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
